// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers of the 5-stage MIPS core: PC, F/D and D/E.
// A stall holds PC and F/D, injects a bubble into D/E and counts the stall cycle.
module pipe_front_regs #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] NOP      = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      npc,
  input  logic [31:0]      F_instr,
  input  logic [31:0]      D_rs_data,
  input  logic [31:0]      D_rt_data,
  input  logic [31:0]      D_ext,
  output logic [31:0]      F_pc,
  output logic [31:0]      D_instr,
  output logic [31:0]      D_pc,
  output logic [31:0]      E_instr,
  output logic [31:0]      E_pc,
  output logic [31:0]      E_rs_data,
  output logic [31:0]      E_rt_data,
  output logic [31:0]      E_ext,
  output logic             E_bubble,
  output logic [CNT_W-1:0] stall_count
);

  logic cnt_sat;
  assign cnt_sat = &stall_count;

  // PC and F/D: hold while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      F_pc    <= PC_RESET;
      D_instr <= NOP;
      D_pc    <= '0;
    end else if (!stall) begin
      F_pc    <= {npc[31:2], 2'b00};
      D_instr <= F_instr;
      D_pc    <= F_pc;
    end
  end

  // D/E: a bubble keeps the stalled PC so E_pc always names the D instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      E_instr   <= NOP;
      E_pc      <= '0;
      E_rs_data <= '0;
      E_rt_data <= '0;
      E_ext     <= '0;
      E_bubble  <= 1'b0;
    end else if (stall) begin
      E_instr   <= NOP;
      E_pc      <= D_pc;
      E_rs_data <= '0;
      E_rt_data <= '0;
      E_ext     <= '0;
      E_bubble  <= 1'b1;
    end else begin
      E_instr   <= D_instr;
      E_pc      <= D_pc;
      E_rs_data <= D_rs_data;
      E_rt_data <= D_rt_data;
      E_ext     <= D_ext;
      E_bubble  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && !cnt_sat) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_front_regs.sv
// Randomized self-checking bench for pipe_front_regs against a cycle-level model
// derived from the pipeline rules; a second instance with a 4-bit counter covers saturation.
module tb_pipe_front_regs;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] npc, F_instr, D_rs_data, D_rt_data, D_ext;

  logic [31:0] F_pc, D_instr, D_pc, E_instr, E_pc, E_rs_data, E_rt_data, E_ext;
  logic        E_bubble;
  logic [31:0] stall_count;

  logic [31:0] s_F_pc, s_D_instr, s_D_pc, s_E_instr, s_E_pc, s_E_rs, s_E_rt, s_E_ext;
  logic        s_E_bubble;
  logic [3:0]  s_stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_front_regs dut (
    .clk(clk), .reset(reset), .stall(stall), .npc(npc), .F_instr(F_instr),
    .D_rs_data(D_rs_data), .D_rt_data(D_rt_data), .D_ext(D_ext),
    .F_pc(F_pc), .D_instr(D_instr), .D_pc(D_pc), .E_instr(E_instr), .E_pc(E_pc),
    .E_rs_data(E_rs_data), .E_rt_data(E_rt_data), .E_ext(E_ext),
    .E_bubble(E_bubble), .stall_count(stall_count)
  );

  pipe_front_regs #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .stall(stall), .npc(npc), .F_instr(F_instr),
    .D_rs_data(D_rs_data), .D_rt_data(D_rt_data), .D_ext(D_ext),
    .F_pc(s_F_pc), .D_instr(s_D_instr), .D_pc(s_D_pc), .E_instr(s_E_instr), .E_pc(s_E_pc),
    .E_rs_data(s_E_rs), .E_rt_data(s_E_rt), .E_ext(s_E_ext),
    .E_bubble(s_E_bubble), .stall_count(s_stall_count)
  );

  // reference model state
  logic [31:0] m_fpc, m_dinstr, m_dpc, m_einstr, m_epc, m_ers, m_ert, m_eext;
  logic        m_ebub;
  longint      m_cnt;
  int          m_cnt4;

  function automatic logic [31:0] im_word(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hA5C3, pc[15:0] + 16'h1111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("F_pc",        F_pc,        m_fpc);
    chk("D_instr",     D_instr,     m_dinstr);
    chk("D_pc",        D_pc,        m_dpc);
    chk("E_instr",     E_instr,     m_einstr);
    chk("E_pc",        E_pc,        m_epc);
    chk("E_rs_data",   E_rs_data,   m_ers);
    chk("E_rt_data",   E_rt_data,   m_ert);
    chk("E_ext",       E_ext,       m_eext);
    chk("E_bubble",    {31'b0, E_bubble}, {31'b0, m_ebub});
    chk("stall_count", stall_count, m_cnt[31:0]);
    chk("sat_F_pc",    s_F_pc,      m_fpc);
    chk("sat_E_instr", s_E_instr,   m_einstr);
    chk("sat_count",   {28'b0, s_stall_count}, m_cnt4[31:0]);
  endtask

  // One clock: drive inputs, apply the pipeline rules to the model, check after the edge.
  task automatic step(input bit rst, input bit stl, input logic [31:0] npc_v);
    reset     = rst;
    stall     = stl;
    npc       = npc_v;
    F_instr   = im_word(m_fpc);
    D_rs_data = $urandom;
    D_rt_data = $urandom;
    D_ext     = $urandom;
    @(posedge clk);
    if (rst) begin
      m_fpc = 32'h3000; m_dinstr = 0; m_dpc = 0;
      m_einstr = 0; m_epc = 0; m_ers = 0; m_ert = 0; m_eext = 0;
      m_ebub = 0; m_cnt = 0; m_cnt4 = 0;
    end else if (stl) begin
      m_einstr = 0; m_epc = m_dpc; m_ers = 0; m_ert = 0; m_eext = 0; m_ebub = 1;
      if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
    end else begin
      m_einstr = m_dinstr; m_epc = m_dpc;
      m_ers = D_rs_data; m_ert = D_rt_data; m_eext = D_ext; m_ebub = 0;
      m_dinstr = F_instr; m_dpc = m_fpc;
      m_fpc = npc_v & 32'hFFFF_FFFC;
    end
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, m_fpc + 32'd4);
  endtask

  task automatic stalls(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, $urandom);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b1; npc = '0; F_instr = '0;
    D_rs_data = '0; D_rt_data = '0; D_ext = '0;
    m_fpc = 0; m_dinstr = 0; m_dpc = 0; m_einstr = 0; m_epc = 0;
    m_ers = 0; m_ert = 0; m_eext = 0; m_ebub = 0; m_cnt = 0; m_cnt4 = 0;

    // reset with stall held high
    step(1'b1, 1'b1, 32'h1234_5678);
    step(1'b1, 1'b1, 32'h1234_5678);
    chk("rst_F_pc_const", F_pc, 32'h0000_3000);

    // free run; first fetched word reaches D then E
    run(1);
    chk("lat_D_A", D_instr, im_word(32'h3000));
    run(1);
    chk("lat_E_A", E_instr, im_word(32'h3000));
    chk("lat_E_pc", E_pc, 32'h3000);
    run(3);

    // single stall then release
    stalls(1);
    chk("stall1_bubble", {31'b0, E_bubble}, 32'd1);
    run(2);

    // three stalls
    stalls(3);
    run(2);

    // reset during the 2nd of 3 stalls
    stalls(1);
    step(1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("midstall_rst_cnt", stall_count, 32'd0);
    stalls(1);
    run(3);

    // long stall saturates the 4-bit counter; npc low bits dropped
    stalls(20);
    chk("sat_15", {28'b0, s_stall_count}, 32'd15);
    step(1'b0, 1'b0, 32'h0000_3007);
    chk("npc_align", F_pc, 32'h0000_3004);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit          r, s;
      logic [31:0] n;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 35);
      n = ($urandom_range(0, 9) == 0) ? $urandom : m_fpc + 32'd4;
      step(r, s, n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
